// File: rtl/ifu_pkg.sv
// Package for the instruction-fetch unit.
// Holds the fetch FSM state type, the PC-update command type driven from
// the FSM into ifu_pc_gen, the AXI OKAY response code and the PC stride.
package ifu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      AR,
      R,
      OUT,
      HALT
   } ifu_state_e;

   // Commands from the FSM to the PC generator, one per cycle.
   typedef enum logic [2:0] {
      PC_HOLD,
      PC_REDIRECT,
      PC_ADVANCE,
      PC_RESUME,
      PC_DEFER
   } pc_op_e;

   localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
   localparam logic [31:0] PC_STEP       = 32'd4;

   // Instructions are word aligned, so the low two bits of any new PC are dropped.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_axil_master_if.sv
// AXI-lite bus between the instruction-fetch master and the instruction SRAM.
// Ports (per modport):
//   master : drives araddr/arvalid/rready and the tied-off write channels,
//            receives arready/rdata/rresp/rvalid and write responses.
//   slave  : the mirror image.
`include "defines.svh"

interface ifu_axil_master_if;

   logic `AXI_ADDR_BUS araddr;
   logic               arvalid;
   logic               arready;

   logic `AXI_DATA_BUS rdata;
   logic [1:0]         rresp;
   logic               rvalid;
   logic               rready;

   logic `AXI_ADDR_BUS awaddr;
   logic               awvalid;
   logic               awready;
   logic `AXI_DATA_BUS wdata;
   logic [3:0]         wstrb;
   logic               wvalid;
   logic               wready;
   logic [1:0]         bresp;
   logic               bvalid;
   logic               bready;

   modport master (
      output araddr, arvalid, rready,
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready,
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid,
      output awready, wready, bresp, bvalid
   );

endinterface

// File: rtl/defines.svh
// Shared bus-width and instruction macros for the instruction-fetch slice.
//   AXI_ADDR_BUS : packed range of an AXI-lite address (32 bits)
//   AXI_DATA_BUS : packed range of an AXI-lite data word (32 bits)
//   INST_NOP     : canonical RISC-V NOP (addi x0, x0, 0)
`ifndef IFU_DEFINES_SVH
`define IFU_DEFINES_SVH
`define AXI_ADDR_BUS [31:0]
`define AXI_DATA_BUS [31:0]
`define INST_NOP 32'h0000_0013
`endif

// File: rtl/ifu_pc_gen.sv
// PC generator for the fetch unit.
// Owns the fetch PC, the pending redirect target and the drop flag that marks
// the in-flight AXI read as stale.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   op           : update command from the fetch FSM
//   redirect_pc  : redirect target (low two bits ignored)
//   pc           : address of the current/next fetch
//   drop         : the outstanding read belongs to a superseded PC
`include "defines.svh"

module ifu_pc_gen
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  pc_op_e             op,
   input  logic `AXI_ADDR_BUS redirect_pc,
   output logic `AXI_ADDR_BUS pc,
   output logic               drop
);

   logic `AXI_ADDR_BUS pend_pc;

   // A redirect arriving mid-transaction cannot move araddr, so it is parked
   // in pend_pc and applied when the stale response comes back (PC_RESUME).
   // A later redirect simply overwrites the parked target.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= RESET_PC;
         pend_pc <= '0;
         drop    <= 1'b0;
      end else begin
         case (op)
            PC_REDIRECT: begin
               pc   <= align_pc(redirect_pc);
               drop <= 1'b0;
            end
            PC_ADVANCE: pc <= pc + PC_STEP;
            PC_RESUME: begin
               pc   <= pend_pc;
               drop <= 1'b0;
            end
            PC_DEFER: begin
               pend_pc <= align_pc(redirect_pc);
               drop    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ifu_axil_master.sv
// Instruction-fetch AXI-lite master.
// Holds the PC, issues one AR read per instruction and presents
// {inst, inst_pc, fetch_err} to decode over a valid/ready handshake.
// Read-only, never more than one transaction in flight; PC redirects from
// execute take priority over everything else in the same cycle.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   redirect_valid/redirect_pc: one-cycle restart request and target
//   inst_valid/inst_ready     : decode handshake
//   inst, inst_pc, fetch_err  : fetched word, its address, error flag
//   bus                       : AXI-lite master (write channels tied off)
// Optional feature: define IFU_TIMEOUT_EN to abort a read after
// TIMEOUT_CYCLES cycles, present a NOP with fetch_err and then halt.
`include "defines.svh"

module ifu_axil_master
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h8000_0000,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic `AXI_ADDR_BUS redirect_pc,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic `AXI_DATA_BUS inst,
   output logic `AXI_ADDR_BUS inst_pc,
   output logic               fetch_err,
   ifu_axil_master_if.master  bus
);

   ifu_state_e         state;
   logic               arvalid_q;
   logic               rready_q;
   logic `AXI_ADDR_BUS pc;
   logic               drop;
   pc_op_e             pc_op;
   logic               in_flight;
   logic               completion;
   logic               unused_inputs;

   ifu_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
      .clk         (clk),
      .rst         (rst),
      .op          (pc_op),
      .redirect_pc (redirect_pc),
      .pc          (pc),
      .drop        (drop)
   );

   assign bus.araddr  = pc;
   assign bus.arvalid = arvalid_q;
   assign bus.rready  = rready_q;
   assign bus.awaddr  = '0;
   assign bus.awvalid = 1'b0;
   assign bus.wdata   = '0;
   assign bus.wstrb   = '0;
   assign bus.wvalid  = 1'b0;
   assign bus.bready  = 1'b1;

   assign unused_inputs = &{1'b0, bus.awready, bus.wready, bus.bresp, bus.bvalid,
                            (TIMEOUT_CYCLES > 0)};

   // The slave may return R in the same cycle it accepts AR, so completion
   // is recognised in AR as well as in R.
   assign in_flight  = (state == AR) || (state == R);
   assign completion = ((state == AR) && bus.arready && bus.rvalid) ||
                       ((state == R) && bus.rvalid);

`ifdef IFU_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt;
   logic            timed_out;
   logic            timeout_hit;

   assign timeout_hit = in_flight && !completion && !redirect_valid &&
                        (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Counts cycles of the current transaction; restarts whenever a new read
   // begins. timed_out steers the next decode handshake into HALT.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt    <= '0;
         timed_out <= 1'b0;
      end else begin
         if (!in_flight || completion) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
         if (timeout_hit) begin
            timed_out <= 1'b1;
         end else if ((state == OUT) && redirect_valid) begin
            timed_out <= 1'b0;
         end
      end
   end
`endif

   // PC command selection: redirects win, a stale response restores the
   // parked target, and a decode handshake steps to the next word.
   always_comb begin
      pc_op = PC_HOLD;
      case (state)
         IDLE: if (redirect_valid) pc_op = PC_REDIRECT;
         AR, R: begin
            if (redirect_valid) begin
               pc_op = completion ? PC_REDIRECT : PC_DEFER;
            end else if (completion && drop) begin
               pc_op = PC_RESUME;
            end
         end
         OUT: begin
            if (redirect_valid) begin
               pc_op = PC_REDIRECT;
            end else if (inst_ready) begin
               pc_op = PC_ADVANCE;
            end
         end
         default: ;
      endcase
   end

   // Fetch FSM with registered AXI and decode outputs. A response that is
   // stale (drop) or overtaken by a same-cycle redirect is discarded and a
   // new read starts immediately from the updated PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         inst_valid <= 1'b0;
         inst       <= `INST_NOP;
         inst_pc    <= '0;
         fetch_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state     <= AR;
               arvalid_q <= 1'b1;
               rready_q  <= 1'b1;
            end
            AR, R: begin
               if (completion) begin
                  if (redirect_valid || drop) begin
                     state     <= AR;
                     arvalid_q <= 1'b1;
                     rready_q  <= 1'b1;
                  end else begin
                     state      <= OUT;
                     arvalid_q  <= 1'b0;
                     rready_q   <= 1'b0;
                     inst_valid <= 1'b1;
                     inst       <= bus.rdata;
                     inst_pc    <= pc;
                     fetch_err  <= (bus.rresp != AXI_RESP_OKAY);
                  end
`ifdef IFU_TIMEOUT_EN
               end else if (timeout_hit) begin
                  state      <= OUT;
                  arvalid_q  <= 1'b0;
                  rready_q   <= 1'b0;
                  inst_valid <= 1'b1;
                  inst       <= `INST_NOP;
                  inst_pc    <= pc;
                  fetch_err  <= 1'b1;
`endif
               end else if ((state == AR) && bus.arready) begin
                  state     <= R;
                  arvalid_q <= 1'b0;
               end
            end
            OUT: begin
               if (redirect_valid) begin
                  state      <= AR;
                  inst_valid <= 1'b0;
                  arvalid_q  <= 1'b1;
                  rready_q   <= 1'b1;
               end else if (inst_ready) begin
                  inst_valid <= 1'b0;
`ifdef IFU_TIMEOUT_EN
                  if (timed_out) begin
                     state     <= HALT;
                     arvalid_q <= 1'b0;
                     rready_q  <= 1'b1;
                  end else begin
                     state     <= AR;
                     arvalid_q <= 1'b1;
                     rready_q  <= 1'b1;
                  end
`else
                  state     <= AR;
                  arvalid_q <= 1'b1;
                  rready_q  <= 1'b1;
`endif
               end
            end
            HALT: ;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_axil_master.sv
module tb_ifu_axil_master;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef IFU_TIMEOUT_EN
   localparam int TO_CYCLES = 16;
`else
   localparam int TO_CYCLES = 256;
`endif
   localparam int MODE_COMB    = 0;
   localparam int MODE_DELAYED = 1;
   localparam int MODE_SILENT  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        fetch_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifu_axil_master_if axi ();

   ifu_axil_master #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .fetch_err      (fetch_err),
      .bus            (axi)
   );

   // Instruction memory contents seen by the slave and the model.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0413;
      if (a == 32'h8000_0200) return 32'hDEAD_BEEF;
      return {a[15:0], a[31:16]} ^ 32'h0000_0033;
   endfunction

   function automatic logic memErr(input logic [31:0] a);
      return (a == 32'h8000_0200);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   // Slave: combined handshake, delayed AR/R, or silent.
   int          slave_mode = MODE_COMB;
   int          ar_delay   = 0;
   int          r_delay    = 0;
   int          ar_wait;
   int          r_wait;
   logic        r_pend;
   logic [31:0] r_addr;
   int          outst;

   always_comb begin
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rdata   = '0;
      axi.rresp   = 2'b00;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bresp   = 2'b00;
      axi.bvalid  = 1'b0;
      if (slave_mode == MODE_COMB) begin
         axi.arready = 1'b1;
         axi.rvalid  = axi.arvalid;
         axi.rdata   = memWord(axi.araddr);
         axi.rresp   = memErr(axi.araddr) ? 2'b10 : 2'b00;
      end else if (slave_mode == MODE_DELAYED) begin
         axi.arready = axi.arvalid && (ar_wait >= ar_delay) && !r_pend;
         axi.rvalid  = r_pend && (r_wait >= r_delay);
         axi.rdata   = memWord(r_addr);
         axi.rresp   = memErr(r_addr) ? 2'b10 : 2'b00;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         ar_wait <= 0;
         r_wait  <= 0;
         r_pend  <= 1'b0;
         r_addr  <= '0;
         outst   <= 0;
      end else begin
         outst <= outst + ((axi.arvalid && axi.arready) ? 1 : 0)
                        - ((axi.rvalid && axi.rready) ? 1 : 0);
         if (slave_mode == MODE_DELAYED) begin
            if (axi.arvalid && axi.arready) begin
               r_pend  <= 1'b1;
               r_addr  <= axi.araddr;
               r_wait  <= 0;
               ar_wait <= 0;
            end else begin
               if (axi.arvalid && !r_pend) ar_wait <= ar_wait + 1;
               else if (!axi.arvalid)      ar_wait <= 0;
               if (r_pend) begin
                  if (axi.rvalid && axi.rready) r_pend <= 1'b0;
                  else                          r_wait <= r_wait + 1;
               end
            end
         end
      end
   end

   // Model: model_pc is the address of the next instruction decode must see.
   // Redirects replace it, accepted instructions advance it by 4. Addresses
   // superseded by a redirect may still appear once on AR (stale reads).
   logic [31:0] model_pc = RESET_PC;
   logic [31:0] stale_q[$];
   logic        model_halted  = 1'b0;
   logic        expect_timeout = 1'b0;
   logic        prev_ar_wait  = 1'b0;
   logic [31:0] prev_araddr   = '0;

   always @(negedge clk) begin : compare
      logic [31:0] exp_addr;
      if (rst) begin
         model_pc     = RESET_PC;
         stale_q.delete();
         model_halted = 1'b0;
         prev_ar_wait = 1'b0;
      end else begin
         if (prev_ar_wait && !inst_valid) checkOutput("arvalid_hold", axi.arvalid, 1'b1);
         if (prev_ar_wait && axi.arvalid) checkOutput("araddr_stable", axi.araddr, prev_araddr);
         if (axi.arvalid && axi.arready) begin
            exp_addr = model_pc;
            foreach (stale_q[i]) if (stale_q[i] == axi.araddr) exp_addr = stale_q[i];
            checkOutput("ar_addr", axi.araddr, exp_addr);
            checkOutput("outstanding", outst, 0);
         end
         if (inst_valid) begin
            if (expect_timeout) begin
               checkOutput("model_inst", inst, NOP);
               checkOutput("model_err", fetch_err, 1'b1);
            end else begin
               checkOutput("model_inst", inst, memWord(model_pc));
               checkOutput("model_err", fetch_err, memErr(model_pc));
            end
            checkOutput("model_inst_pc", inst_pc, model_pc);
            stale_q.delete();
         end
         if (model_halted) checkOutput("halt_arvalid", axi.arvalid, 1'b0);
         prev_ar_wait = axi.arvalid && !axi.arready;
         prev_araddr  = axi.araddr;
         if (redirect_valid && !model_halted) begin
            if (!inst_valid) stale_q.push_back(model_pc);
            model_pc = {redirect_pc[31:2], 2'b00};
         end else if (inst_valid && inst_ready) begin
            if (expect_timeout) model_halted = 1'b1;
            else                model_pc     = model_pc + 32'd4;
         end
      end
   end

   task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc,
                                input logic rdy);
      @(posedge clk);
      #1;
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      inst_ready     = rdy;
   endtask

   task automatic waitInst(input string name, input int max);
      int n = 0;
      @(negedge clk);
      while (!inst_valid && n < max) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, inst_valid, 1'b1);
   endtask

   task automatic waitArvalid(input string name, input int max);
      int n = 0;
      @(negedge clk);
      while (!axi.arvalid && n < max) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, axi.arvalid, 1'b1);
   endtask

   task automatic waitArHandshake(input string name, input int max);
      int n = 0;
      @(negedge clk);
      while (!(axi.arvalid && axi.arready) && n < max) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, axi.arvalid && axi.arready, 1'b1);
   endtask

   task automatic pulseReady();
      applyStimulus(0, 0, 32'h0, 1);
      applyStimulus(0, 0, 32'h0, 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : main
      int n;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      inst_ready     = 1'b0;

      // Reset held for several cycles.
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("reset_arvalid", axi.arvalid, 1'b0);
         checkOutput("reset_inst_valid", inst_valid, 1'b0);
      end
      checkOutput("reset_inst", inst, NOP);
      checkOutput("reset_inst_pc", inst_pc, 32'h0);
      applyStimulus(0, 0, 32'h0, 0);
      @(negedge clk);
      checkOutput("idle_arvalid", axi.arvalid, 1'b0);
      @(negedge clk);
      checkOutput("first_arvalid", axi.arvalid, 1'b1);
      checkOutput("first_araddr", axi.araddr, 32'h8000_0000);

      // Combined handshake: instruction one cycle after AR.
      @(negedge clk);
      checkOutput("first_inst_valid", inst_valid, 1'b1);
      checkOutput("first_inst", inst, 32'h0000_0413);
      checkOutput("first_inst_pc", inst_pc, 32'h8000_0000);

      // Back-pressure from decode.
      repeat (5) begin
         @(negedge clk);
         checkOutput("hold_valid", inst_valid, 1'b1);
         checkOutput("hold_inst", inst, 32'h0000_0413);
         checkOutput("hold_err", fetch_err, 1'b0);
         checkOutput("hold_arvalid", axi.arvalid, 1'b0);
      end
      pulseReady();
      @(negedge clk);
      checkOutput("next_araddr", axi.araddr, 32'h8000_0004);

      // Streaming at full rate.
      applyStimulus(0, 0, 32'h0, 1);
      repeat (10) @(posedge clk);
      applyStimulus(0, 0, 32'h0, 0);
      waitInst("stream_settle", 10);

      // Redirect while in R: response dropped, refetch from target.
      slave_mode = MODE_DELAYED;
      ar_delay   = 1;
      r_delay    = 3;
      applyStimulus(0, 0, 32'h0, 1);
      waitArHandshake("drop_ar_hs", 20);
      applyStimulus(0, 1, 32'h8000_0101, 0);
      applyStimulus(0, 0, 32'h0, 0);
      n = 0;
      @(negedge clk);
      while (!axi.arvalid && n < 30) begin
         checkOutput("drop_no_inst", inst_valid, 1'b0);
         @(negedge clk);
         n++;
      end
      checkOutput("drop_arvalid", axi.arvalid, 1'b1);
      checkOutput("drop_araddr", axi.araddr, 32'h8000_0100);
      waitInst("drop_refetch", 30);
      checkOutput("drop_inst_pc", inst_pc, 32'h8000_0100);

      // Two redirects while AR waits: the later one wins.
      ar_delay = 4;
      r_delay  = 1;
      applyStimulus(0, 0, 32'h0, 1);
      applyStimulus(0, 1, 32'h8000_0300, 0);
      applyStimulus(0, 1, 32'h8000_0400, 0);
      applyStimulus(0, 0, 32'h0, 0);
      waitInst("double_redirect", 40);
      checkOutput("double_inst_pc", inst_pc, 32'h8000_0400);

      // Error response, redirect beating a same-cycle handshake.
      slave_mode = MODE_COMB;
      applyStimulus(0, 1, 32'h8000_0200, 1);
      applyStimulus(0, 0, 32'h0, 0);
      waitInst("err_inst", 10);
      checkOutput("err_flag", fetch_err, 1'b1);
      checkOutput("err_inst_word", inst, 32'hDEAD_BEEF);
      checkOutput("err_inst_pc", inst_pc, 32'h8000_0200);

      // PC wrap at the top of the address space.
      applyStimulus(0, 1, 32'hFFFF_FFFC, 0);
      applyStimulus(0, 0, 32'h0, 0);
      waitInst("wrap_top", 10);
      checkOutput("wrap_top_pc", inst_pc, 32'hFFFF_FFFC);
      pulseReady();
      waitArvalid("wrap_ar", 10);
      checkOutput("wrap_araddr", axi.araddr, 32'h0000_0000);
      waitInst("wrap_zero", 10);
      checkOutput("wrap_zero_pc", inst_pc, 32'h0000_0000);

      // Reset in the middle of a transaction.
      slave_mode = MODE_DELAYED;
      ar_delay   = 0;
      r_delay    = 6;
      applyStimulus(0, 0, 32'h0, 1);
      waitArHandshake("midrst_ar_hs", 20);
      applyStimulus(1, 0, 32'h0, 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_arvalid", axi.arvalid, 1'b0);
      checkOutput("midrst_inst_valid", inst_valid, 1'b0);
      checkOutput("midrst_inst", inst, NOP);
      applyStimulus(0, 0, 32'h0, 0);
      waitArvalid("midrst_ar", 10);
      checkOutput("midrst_araddr", axi.araddr, 32'h8000_0000);
      waitInst("midrst_inst_after", 20);
      checkOutput("midrst_inst_word", inst, 32'h0000_0413);

`ifdef IFU_TIMEOUT_EN
      // Silent slave: abort after the timeout, then halt.
      slave_mode     = MODE_SILENT;
      expect_timeout = 1'b1;
      pulseReady();
      n = 0;
      @(negedge clk);
      checkOutput("to_arvalid", axi.arvalid, 1'b1);
      while (!inst_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput("to_latency", n, 16);
      checkOutput("to_inst", inst, NOP);
      checkOutput("to_err", fetch_err, 1'b1);
      pulseReady();
      applyStimulus(0, 1, 32'h8000_0000, 0);
      applyStimulus(0, 0, 32'h0, 0);
      repeat (30) begin
         @(negedge clk);
         checkOutput("halt_ar", axi.arvalid, 1'b0);
         checkOutput("halt_inst_valid", inst_valid, 1'b0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
